// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [INSTR_WIDTH-1:0] HALT_ADDRESS_DEFAULT = 32'h00000000;

    // RUN fetches every unstalled cycle; DRAIN retires the delay slot of a
    // halting jump; HALTED and FAULT are terminal until reset.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode-side outputs and the
// branch/stall controls coming back from execute.
//
// Flow control: there is no valid/ready pair here. stall=1 freezes every
// register in the fetch unit for that cycle; branch_taken/branch_target are
// only consumed on a cycle with stall=0, so the producer holds them asserted
// until such a cycle occurs. instr_valid qualifies instr_out/pc_out.
interface instruction_fetch_unit_if;
    import mips_cpu_pkg::*;

    logic                   stall;
    logic                   branch_taken;
    logic [INSTR_WIDTH-1:0] branch_target;
    logic [INSTR_WIDTH-1:0] instr_readdata;
    logic [INSTR_WIDTH-1:0] instr_address;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [INSTR_WIDTH-1:0] pc_out;
    logic                   instr_valid;
    logic                   active;
    logic                   misaligned;

    // Fetch unit side.
    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  instr_readdata,
        output instr_address,
        output instr_out,
        output pc_out,
        output instr_valid,
        output active,
        output misaligned
    );

    // Memory / decode / execute side.
    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output instr_readdata,
        input  instr_address,
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        input  active,
        input  misaligned
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and instruction register with MIPS delay-slot branching
// and halt-on-jump-to-HALT_ADDRESS.
module instruction_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [INSTR_WIDTH-1:0] HALT_ADDRESS = HALT_ADDRESS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus,
    output fetch_state_t             state_dbg
);

    fetch_state_t           state_q, state_d;
    logic [INSTR_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [INSTR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                   valid_q, valid_d;
    logic                   active_q, active_d;
    logic                   mis_q, mis_d;

    logic                   target_misaligned;
    logic                   target_is_halt;

    assign target_misaligned = (bus.branch_target[1:0] != 2'b00);
    assign target_is_halt    = (bus.branch_target == HALT_ADDRESS);

    // Next-state, next-pc and instruction-register update; everything holds
    // by default so a stall simply skips the case statement.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        mis_d    = mis_q;
        if (!bus.stall) begin
            case (state_q)
                RUN: begin
                    // The word latched here is the delay slot when a branch
                    // is taken this cycle, so branches cost no bubbles.
                    ir_d     = bus.instr_readdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    if (bus.branch_taken) begin
                        if (target_misaligned) begin
                            state_d = FAULT;
                            mis_d   = 1'b1;
                        end else if (target_is_halt) begin
                            // pc stays put so HALT_ADDRESS is never fetched.
                            state_d = DRAIN;
                        end else begin
                            pc_d = bus.branch_target;
                        end
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                DRAIN: begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end
                HALTED, FAULT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = FAULT;
                end
            endcase
        end
        active_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // State and datapath registers; reset wins over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_VECTOR;
            ir_q     <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b1;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.instr_address = pc_q;
    assign bus.instr_out     = ir_q;
    assign bus.pc_out        = pc_out_q;
    assign bus.instr_valid   = valid_q;
    assign bus.active        = active_q;
    assign bus.misaligned    = mis_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level fetch model
// compared against the DUT every cycle, plus literal expectations.
module tb_instruction_fetch_unit;
    import mips_cpu_pkg::*;

    logic         clk;
    logic         reset;
    fetch_state_t state_dbg;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every word holds its own byte address.
    assign bus.instr_readdata = bus.instr_address;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = executing, 1 = finishing the delay slot of
    // a halt jump, 2 = stopped (halted or faulted).
    logic [31:0] m_pc, m_ir, m_pc_out;
    logic        m_valid, m_active, m_mis;
    int          m_mode;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'hBFC00000; m_ir = 0; m_pc_out = 0;
            m_valid = 0; m_active = 1; m_mis = 0; m_mode = 0;
        end else if (!bus.stall) begin
            if (m_mode == 0) begin
                m_ir = m_pc;        // memory word equals its address
                m_pc_out = m_pc;
                m_valid = 1;
                if (bus.branch_taken && bus.branch_target[1:0] != 0) begin
                    m_mis = 1; m_mode = 2; m_active = 0;
                end else if (bus.branch_taken && bus.branch_target == 0) begin
                    m_mode = 1;
                end else if (bus.branch_taken) begin
                    m_pc = bus.branch_target;
                end else begin
                    m_pc = m_pc + 4;
                end
            end else begin
                m_valid = 0;
                m_mode = 2;
                m_active = 0;
            end
        end
    end

    // Scoreboard: compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_address", bus.instr_address, m_pc);
            check("instr_out",     bus.instr_out,     m_ir);
            check("pc_out",        bus.pc_out,        m_pc_out);
            check("instr_valid",   {31'd0, bus.instr_valid}, {31'd0, m_valid});
            check("active",        {31'd0, bus.active},      {31'd0, m_active});
            check("misaligned",    {31'd0, bus.misaligned},  {31'd0, m_mis});
        end
    end

    // Driver: apply inputs, advance one edge, land just after the next negedge.
    task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
        reset = rst;
        bus.stall = stl;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        check("rst_addr",   bus.instr_address, 32'hBFC00000);
        check("rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
        check("rst_active", {31'd0, bus.active}, 32'd1);
        check("rst_ir",     bus.instr_out, 32'h0);

        // Free running fetch.
        run(1);
        check("free_ir0",   bus.instr_out, 32'hBFC00000);
        check("free_addr1", bus.instr_address, 32'hBFC00004);
        // Branch while pc_out = BFC00000: delay slot then target.
        step(1'b0, 1'b0, 1'b1, 32'hBFC00100);
        check("br_delay",   bus.instr_out, 32'hBFC00004);
        check("br_valid",   {31'd0, bus.instr_valid}, 32'd1);
        run(1);
        check("br_target",  bus.instr_out, 32'hBFC00100);

        // Stall with branch held: frozen, then applied once.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'hBFC00200);
            check("stall_ir",   bus.instr_out, 32'hBFC00100);
            check("stall_addr", bus.instr_address, 32'hBFC00104);
        end
        step(1'b0, 1'b0, 1'b1, 32'hBFC00200);
        check("unstall_delay", bus.instr_out, 32'hBFC00104);
        run(1);
        check("unstall_tgt",   bus.instr_out, 32'hBFC00200);

        // Reset during stall.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_stall_addr",  bus.instr_address, 32'hBFC00000);
        check("rst_stall_valid", {31'd0, bus.instr_valid}, 32'd0);

        // Jump to HALT_ADDRESS from pc_out = BFC00010.
        run(5);
        check("pre_halt_pcout", bus.pc_out, 32'hBFC00010);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("halt_delay",  bus.instr_out, 32'hBFC00014);
        check("halt_valid",  {31'd0, bus.instr_valid}, 32'd1);
        check("halt_active", {31'd0, bus.active}, 32'd1);
        run(1);
        check("drain_valid",  {31'd0, bus.instr_valid}, 32'd0);
        check("drain_active", {31'd0, bus.active}, 32'd0);
        check("drain_addr",   bus.instr_address, 32'hBFC00014);
        run(2);
        check("halted_addr",  bus.instr_address, 32'hBFC00014);

        // Reset during DRAIN.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(5);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_drain_active", {31'd0, bus.active}, 32'd1);
        check("rst_drain_addr",   bus.instr_address, 32'hBFC00000);

        // PC wrap past the top of the address space.
        run(1);
        step(1'b0, 1'b0, 1'b1, 32'hFFFFFFF8);
        run(2);
        check("wrap_addr", bus.instr_address, 32'h00000000);
        run(1);
        check("wrap_ir",    bus.instr_out, 32'h00000000);
        check("wrap_valid", {31'd0, bus.instr_valid}, 32'd1);

        // Misaligned target: sticky flag, delay slot still valid once.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(1);
        step(1'b0, 1'b0, 1'b1, 32'hBFC00102);
        check("mis_flag",   {31'd0, bus.misaligned}, 32'd1);
        check("mis_active", {31'd0, bus.active}, 32'd0);
        check("mis_delay",  bus.instr_out, 32'hBFC00004);
        check("mis_valid",  {31'd0, bus.instr_valid}, 32'd1);
        run(2);
        check("fault_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("fault_flag",  {31'd0, bus.misaligned}, 32'd1);
        check("fault_addr",  bus.instr_address, 32'hBFC00004);

        // Branch held during a stall in FAULT is ignored.
        step(1'b0, 1'b1, 1'b1, 32'hBFC00300);
        step(1'b0, 1'b0, 1'b1, 32'hBFC00300);
        check("fault_frozen", bus.instr_address, 32'hBFC00004);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
